// File: rtl/complex_mult_pipe_pkg.sv
// Shared types and helpers for the complex-sample datapaths.
package complex_mult_pipe_pkg;

   localparam logic CONJ_EN = 1'b1;
   localparam int   MAX_W   = 64;

   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } sample_t_int;

   // Width-agnostic scalar round/shift/saturate for callers whose widths fit in MAX_W.
   function automatic logic signed [MAX_W-1:0] sat_round(
      input  logic signed [MAX_W-1:0] x,
      input  int                      shift,
      input  logic                    rnd,
      input  int                      z_w,
      output logic                    ovf
   );
      logic signed [MAX_W-1:0] t;
      logic signed [MAX_W-1:0] hi;
      logic signed [MAX_W-1:0] lo;
      t = x;
      if (rnd && shift > 0) t = t + (MAX_W'(1) << (shift - 1));
      t   = t >>> shift;
      hi  = (MAX_W'(1) << (z_w - 1)) - MAX_W'(1);
      lo  = -hi - MAX_W'(1);
      ovf = 1'b0;
      if (t > hi) begin
         t   = hi;
         ovf = 1'b1;
      end else if (t < lo) begin
         t   = lo;
         ovf = 1'b1;
      end
      return t;
   endfunction

endpackage

// File: rtl/complex_mult_pipe_round_sat.sv
// Combinational round, arithmetic right shift and saturate of one signed value.
module complex_mult_pipe_round_sat
   import complex_mult_pipe_pkg::*;
#(
   parameter int IN_W  = 33,
   parameter int Z_W   = 16,
   parameter int SHIFT = 15,
   parameter int ROUND = 1
) (
   input  logic signed [IN_W-1:0] din,
   output logic signed [Z_W-1:0]  dout,
   output logic                   ovf
);

   // One guard bit so the rounding add can never wrap.
   localparam int T_W = IN_W + 1;
   localparam logic DO_RND = (ROUND != 0) && (SHIFT > 0);
   localparam logic signed [T_W-1:0] RND_ADD =
      DO_RND ? (T_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

   logic signed [T_W-1:0] ext;
   logic signed [T_W-1:0] t;

   always_comb begin
      ext = T_W'(din);
      t   = (ext + RND_ADD) >>> SHIFT;
   end

   generate
      if (Z_W < T_W) begin : g_sat
         localparam logic signed [T_W-1:0] ZMAX = (T_W'(1) <<< (Z_W - 1)) - T_W'(1);
         localparam logic signed [T_W-1:0] ZMIN = -ZMAX - T_W'(1);
         always_comb begin
            ovf  = 1'b0;
            dout = t[Z_W-1:0];
            if (t > ZMAX) begin
               dout = ZMAX[Z_W-1:0];
               ovf  = 1'b1;
            end else if (t < ZMIN) begin
               dout = ZMIN[Z_W-1:0];
               ovf  = 1'b1;
            end
         end
      end else begin : g_wide
         always_comb begin
            dout = Z_W'(t);
            ovf  = 1'b0;
         end
      end
   endgenerate

endmodule

// File: rtl/complex_mult_pipe.sv
// Flow-controlled complex multiplier z = a*b or a*conj(b), scaled, rounded and saturated.
module complex_mult_pipe
   import complex_mult_pipe_pkg::*;
#(
   parameter int A_W      = 16,
   parameter int B_W      = 16,
   parameter int Z_W      = 16,
   parameter int SHIFT    = 15,
   parameter int ROUND    = 1,
   parameter int PIPE_NUM = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic signed [A_W-1:0] s_a_re,
   input  logic signed [A_W-1:0] s_a_im,
   input  logic signed [B_W-1:0] s_b_re,
   input  logic signed [B_W-1:0] s_b_im,
   input  logic                  s_conj,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic signed [Z_W-1:0] m_z_re,
   output logic signed [Z_W-1:0] m_z_im,
   output logic                  m_last,
   output logic                  m_ovf
);

   localparam int M_W = A_W + B_W;
   localparam int P   = M_W + 1;
   localparam int D   = PIPE_NUM - 2;

   logic [PIPE_NUM-1:0] v;
   logic [PIPE_NUM-1:0] ld;

   logic signed [M_W-1:0] p_rr, p_ii, p_ri, p_ir;
   logic                  c0, l0;
   logic signed [P-1:0]   sum_re, sum_im;
   logic signed [P-1:0]   fin_re, fin_im;
   logic                  fin_last;
   logic signed [Z_W-1:0] rs_re, rs_im;
   logic                  ovf_re, ovf_im;

   // A stage may load when empty or when its content moves on; this ripples back from m_ready.
   always_comb begin
      logic go;
      go = m_ready;
      for (int i = PIPE_NUM - 1; i >= 0; i--) begin
         go    = !v[i] || go;
         ld[i] = go;
      end
   end

   assign s_ready = ld[0];
   assign m_valid = v[PIPE_NUM-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
      end else begin
         if (ld[0]) v[0] <= s_valid;
         for (int i = 1; i < PIPE_NUM; i++) begin
            if (ld[i]) v[i] <= v[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_rr <= '0;
         p_ii <= '0;
         p_ri <= '0;
         p_ir <= '0;
         c0   <= 1'b0;
         l0   <= 1'b0;
      end else if (ld[0] && s_valid) begin
         p_rr <= M_W'(s_a_re) * M_W'(s_b_re);
         p_ii <= M_W'(s_a_im) * M_W'(s_b_im);
         p_ri <= M_W'(s_a_re) * M_W'(s_b_im);
         p_ir <= M_W'(s_a_im) * M_W'(s_b_re);
         c0   <= s_conj;
         l0   <= s_last;
      end
   end

   always_comb begin
      if (c0 == CONJ_EN) begin
         sum_re = P'(p_rr) + P'(p_ii);
         sum_im = P'(p_ir) - P'(p_ri);
      end else begin
         sum_re = P'(p_rr) - P'(p_ii);
         sum_im = P'(p_ri) + P'(p_ir);
      end
   end

   // With only two stages the sums feed the output stage directly.
   generate
      if (D == 0) begin : g_nodly
         assign fin_re   = sum_re;
         assign fin_im   = sum_im;
         assign fin_last = l0;
      end else begin : g_dly
         logic signed [P-1:0] dre [D];
         logic signed [P-1:0] dim [D];
         logic [D-1:0]        dlast;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < D; k++) begin
                  dre[k] <= '0;
                  dim[k] <= '0;
               end
               dlast <= '0;
            end else begin
               if (ld[1] && v[0]) begin
                  dre[0]   <= sum_re;
                  dim[0]   <= sum_im;
                  dlast[0] <= l0;
               end
               for (int k = 1; k < D; k++) begin
                  if (ld[k+1] && v[k]) begin
                     dre[k]   <= dre[k-1];
                     dim[k]   <= dim[k-1];
                     dlast[k] <= dlast[k-1];
                  end
               end
            end
         end

         assign fin_re   = dre[D-1];
         assign fin_im   = dim[D-1];
         assign fin_last = dlast[D-1];
      end
   endgenerate

   complex_mult_pipe_round_sat #(
      .IN_W (P),
      .Z_W  (Z_W),
      .SHIFT(SHIFT),
      .ROUND(ROUND)
   ) u_rs_re (
      .din (fin_re),
      .dout(rs_re),
      .ovf (ovf_re)
   );

   complex_mult_pipe_round_sat #(
      .IN_W (P),
      .Z_W  (Z_W),
      .SHIFT(SHIFT),
      .ROUND(ROUND)
   ) u_rs_im (
      .din (fin_im),
      .dout(rs_im),
      .ovf (ovf_im)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_z_re <= '0;
         m_z_im <= '0;
         m_last <= 1'b0;
         m_ovf  <= 1'b0;
      end else if (ld[PIPE_NUM-1] && v[PIPE_NUM-2]) begin
         m_z_re <= rs_re;
         m_z_im <= rs_im;
         m_last <= fin_last;
         m_ovf  <= ovf_re | ovf_im;
      end
   end

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Scoreboard bench: a rounding instance under random backpressure and a truncating instance that never stalls.
module tb_complex_mult_pipe;

   localparam int A_W      = 16;
   localparam int B_W      = 16;
   localparam int Z_W      = 16;
   localparam int SHIFT    = 15;
   localparam int PIPE_NUM = 4;

   typedef struct {
      int re;
      int im;
      bit last;
      bit ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic s_valid = 1'b0, s_conj = 1'b0, s_last = 1'b0, m_ready = 1'b1;
   logic signed [A_W-1:0] s_a_re = '0, s_a_im = '0;
   logic signed [B_W-1:0] s_b_re = '0, s_b_im = '0;
   logic s_ready, m_valid, m_last, m_ovf;
   logic signed [Z_W-1:0] m_z_re, m_z_im;

   logic t_s_valid, t_s_ready, t_m_valid, t_m_last, t_m_ovf;
   logic t_m_ready = 1'b1;
   logic signed [Z_W-1:0] t_m_z_re, t_m_z_im;

   exp_t exp_q[$];
   exp_t trunc_q[$];
   exp_t e, et;
   int checks = 0;
   int errors = 0;
   int occ = 0;
   bit was_stall = 0;
   int bp_mode = 0;

   always #5 clk = ~clk;

   assign t_s_valid = s_valid && s_ready;

   complex_mult_pipe #(
      .A_W(A_W), .B_W(B_W), .Z_W(Z_W), .SHIFT(SHIFT), .ROUND(1), .PIPE_NUM(PIPE_NUM)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_a_re(s_a_re), .s_a_im(s_a_im), .s_b_re(s_b_re), .s_b_im(s_b_im),
      .s_conj(s_conj), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_z_re(m_z_re), .m_z_im(m_z_im), .m_last(m_last), .m_ovf(m_ovf)
   );

   complex_mult_pipe #(
      .A_W(A_W), .B_W(B_W), .Z_W(Z_W), .SHIFT(SHIFT), .ROUND(0), .PIPE_NUM(PIPE_NUM)
   ) dut_trunc (
      .clk(clk), .rst_n(rst_n),
      .s_valid(t_s_valid), .s_ready(t_s_ready),
      .s_a_re(s_a_re), .s_a_im(s_a_im), .s_b_re(s_b_re), .s_b_im(s_b_im),
      .s_conj(s_conj), .s_last(s_last),
      .m_valid(t_m_valid), .m_ready(t_m_ready),
      .m_z_re(t_m_z_re), .m_z_im(t_m_z_im), .m_last(t_m_last), .m_ovf(t_m_ovf)
   );

   task automatic check(input string name, input bit ok, input string got, input string want);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s: got %s, expected %s", name, got, want);
      end
   endtask

   // Floor division by 2^SHIFT, then clip to the signed Z_W range.
   function automatic int scale(input longint s, input bit rnd, output bit clip);
      longint d  = longint'(1) << SHIFT;
      longint n  = s + (rnd ? d / 2 : 0);
      longint q  = n / d;
      longint hi = (longint'(1) << (Z_W - 1)) - 1;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      clip = (q > hi) || (q < -hi - 1);
      if (q > hi) q = hi;
      else if (q < -hi - 1) q = -hi - 1;
      return int'(q);
   endfunction

   function automatic exp_t model(input int ar, input int ai, input int br, input int bi,
                                  input bit conj, input bit last, input bit rnd);
      longint re, im;
      bit cr, ci;
      exp_t r;
      if (conj) begin
         re = longint'(ar) * br + longint'(ai) * bi;
         im = longint'(ai) * br - longint'(ar) * bi;
      end else begin
         re = longint'(ar) * br - longint'(ai) * bi;
         im = longint'(ar) * bi + longint'(ai) * br;
      end
      r.re   = scale(re, rnd, cr);
      r.im   = scale(im, rnd, ci);
      r.last = last;
      r.ovf  = cr | ci;
      return r;
   endfunction

   function automatic string fmt(input int re, input int im, input bit last, input bit ovf);
      return $sformatf("re=%0d im=%0d last=%0b ovf=%0b", re, im, last, ovf);
   endfunction

   function automatic int pick();
      logic signed [15:0] x;
      int r = $urandom_range(0, 9);
      if (r == 0) return -32768;
      if (r == 1) return 32767;
      x = 16'($urandom);
      return int'(x);
   endfunction

   // Called at posedge+2; holds the sample until accepted, returns at posedge+2 after the accepting edge.
   task automatic applyStimulus(input int ar, input int ai, input int br, input int bi,
                                input bit conj, input bit last);
      s_valid = 1'b1;
      s_a_re  = 16'(ar);
      s_a_im  = 16'(ai);
      s_b_re  = 16'(br);
      s_b_im  = 16'(bi);
      s_conj  = conj;
      s_last  = last;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (s_ready) begin
            exp_q.push_back(model(ar, ai, br, bi, conj, last, 1'b1));
            trunc_q.push_back(model(ar, ai, br, bi, conj, last, 1'b0));
            @(posedge clk);
            #2;
            s_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #2;
      end
      check("send_timeout", 1'b0, "s_ready stuck low", "accept within 200 cycles");
      s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string name);
      int first = 0;
      int cnt = 0;
      for (int i = 1; i <= PIPE_NUM + 4; i++) begin
         @(negedge clk);
         if (m_valid) begin
            if (first == 0) first = i;
            cnt++;
         end
      end
      check({name, "_latency"}, first == PIPE_NUM, $sformatf("%0d", first), $sformatf("%0d", PIPE_NUM));
      check({name, "_valid_len"}, cnt == 1, $sformatf("%0d", cnt), "1");
      idle(1);
   endtask

   task automatic drain();
      for (int n = 0; n < 500 && (exp_q.size() + trunc_q.size()) > 0; n++) @(posedge clk);
      check("drain", exp_q.size() == 0 && trunc_q.size() == 0,
            $sformatf("%0d/%0d pending", exp_q.size(), trunc_q.size()), "0/0 pending");
      #2;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (bp_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 99) >= 30);
            default: m_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares presented outputs with the queue head, pops on transfer.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset_out",
               !m_valid && m_z_re == 0 && m_z_im == 0 && !m_last && !m_ovf && !t_m_valid,
               $sformatf("v=%0b %s tv=%0b", m_valid, fmt(int'(m_z_re), int'(m_z_im), m_last, m_ovf), t_m_valid),
               "all zero");
         exp_q.delete();
         trunc_q.delete();
         occ       = 0;
         was_stall = 0;
      end else begin
         check("s_ready", s_ready == !(occ == PIPE_NUM && !m_ready),
               $sformatf("%0b (occ=%0d m_ready=%0b)", s_ready, occ, m_ready),
               $sformatf("%0b", !(occ == PIPE_NUM && !m_ready)));
         if (was_stall) check("hold_valid", m_valid, "m_valid=0", "m_valid=1 while stalled");
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1'b0, fmt(int'(m_z_re), int'(m_z_im), m_last, m_ovf), "no output");
            end else begin
               e = exp_q[0];
               check("out", int'(m_z_re) == e.re && int'(m_z_im) == e.im && m_last == e.last && m_ovf == e.ovf,
                     fmt(int'(m_z_re), int'(m_z_im), m_last, m_ovf), fmt(e.re, e.im, e.last, e.ovf));
               if (m_ready) void'(exp_q.pop_front());
            end
         end
         if (t_s_valid) check("trunc_s_ready", t_s_ready, "0", "1");
         if (t_m_valid) begin
            if (trunc_q.size() == 0) begin
               check("trunc_unexpected", 1'b0, fmt(int'(t_m_z_re), int'(t_m_z_im), t_m_last, t_m_ovf), "no output");
            end else begin
               et = trunc_q.pop_front();
               check("trunc_out",
                     int'(t_m_z_re) == et.re && int'(t_m_z_im) == et.im && t_m_last == et.last && t_m_ovf == et.ovf,
                     fmt(int'(t_m_z_re), int'(t_m_z_im), t_m_last, t_m_ovf), fmt(et.re, et.im, et.last, et.ovf));
            end
         end
         was_stall = m_valid && !m_ready;
         occ = occ + ((s_valid && s_ready) ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle(1);

      $display("[TB] basic product and latency");
      applyStimulus(16384, 0, 16384, 16384, 0, 0);
      checkOutput("basic");

      $display("[TB] conj back-to-back");
      applyStimulus(0, 16384, 0, 16384, 0, 0);
      applyStimulus(0, 16384, 0, 16384, 1, 0);
      idle(6);

      $display("[TB] saturation and rounding");
      applyStimulus(-32768, 0, -32768, 0, 0, 0);
      applyStimulus(-32768, 0, 32767, 0, 0, 0);
      applyStimulus(1, 0, 16384, 0, 0, 0);
      idle(6);

      $display("[TB] random stream under backpressure");
      bp_mode = 1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(pick(), pick(), pick(), pick(), 1'($urandom_range(0, 1)), i == 19);
         if ($urandom_range(0, 4) == 0) idle(1);
      end
      bp_mode = 0;
      drain();

      $display("[TB] reset with samples in flight");
      bp_mode = 2;
      idle(2);
      for (int i = 0; i < 3; i++) applyStimulus(pick(), pick(), pick(), pick(), 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("reset_immediate", !m_valid && m_z_re == 0 && m_z_im == 0 && !m_last && !m_ovf,
            fmt(int'(m_z_re), int'(m_z_im), m_last, m_ovf), "m_valid=0 and outputs zero");
      bp_mode = 0;
      idle(2);
      rst_n = 1'b1;
      idle(5);
      applyStimulus(12345, -2222, -30000, 4321, 1'b1, 1'b1);
      checkOutput("post_reset");
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
